// File: rtl/sys_issue.sv
// sys_issue: upstream stage of the csr unit.
// Accepts one system instruction (or a pre-flagged exception) from decode and
// builds the op/pc/tval/wdata request for csr. The op is held for exactly one
// cycle. The stage then returns either an rd writeback or a fetch redirect
// with a flush window.
// Optional feature: define SYS_ISSUE_TRACE_EN to add a retire counter and
// per-issue / per-redirect trace prints. Ports and timing do not change.
module sys_issue #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_pc,
  input  logic [31:0] in_insn,
  input  logic [63:0] in_rs1_data,
  input  logic        in_exc_valid,
  input  logic [3:0]  in_exc_cause,
  input  logic [63:0] in_exc_tval,
  input  logic [1:0]  priv,
  output logic [4:0]  op,
  output logic [63:0] pc,
  output logic [63:0] tval,
  output logic [63:0] wdata,
  input  logic [63:0] rdata,
  input  logic        trap_en,
  input  logic [63:0] trap_pc,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush
);

  // csr request codes; bit 4 set means {1'b1, cause} exception request
  localparam logic [4:0] SYSOP_NOP   = 5'd0;
  localparam logic [4:0] SYSOP_CSR_W = 5'd1;
  localparam logic [4:0] SYSOP_CSR_S = 5'd2;
  localparam logic [4:0] SYSOP_CSR_C = 5'd3;
  localparam logic [4:0] SYSOP_RET   = 5'd4;

  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_BREAK   = 4'd3;
  localparam logic [3:0] FLUSH_LOAD    = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  state_e      state_r, state_s;
  logic        in_ready_r, in_ready_s;
  logic [4:0]  op_r, op_s;
  logic [63:0] pc_r, pc_s;
  logic [63:0] tval_r, tval_s;
  logic [63:0] wdata_r, wdata_s;
  logic        wb_valid_r, wb_valid_s;
  logic [4:0]  wb_rd_r, wb_rd_s;
  logic [63:0] wb_data_r, wb_data_s;
  logic        redir_valid_r, redir_valid_s;
  logic [63:0] redir_pc_r, redir_pc_s;
  logic        flush_r, flush_s;
  logic [3:0]  flush_cnt_r, flush_cnt_s;
  logic [4:0]  rd_r, rd_s;
  logic        wb_en_r, wb_en_s;
  logic        fence_r, fence_s;

  // instruction fields
  logic [6:0]  opcode_s;
  logic [4:0]  rd_fld_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_fld_s;
  logic [11:0] imm_s;
  logic [6:0]  funct7_s;

  assign opcode_s  = in_insn[6:0];
  assign rd_fld_s  = in_insn[11:7];
  assign funct3_s  = in_insn[14:12];
  assign rs1_fld_s = in_insn[19:15];
  assign imm_s     = in_insn[31:20];
  assign funct7_s  = in_insn[31:25];

  // decoded request for the instruction currently offered by decode
  logic [4:0]  dec_op_s;
  logic [63:0] dec_tval_s;
  logic [63:0] dec_wdata_s;
  logic        dec_wb_en_s;
  logic        dec_fence_s;

  // Decode the offered instruction; an upstream exception overrides everything
  always_comb begin
    dec_op_s    = SYSOP_NOP;
    dec_tval_s  = 64'd0;
    dec_wdata_s = 64'd0;
    dec_wb_en_s = 1'b0;
    dec_fence_s = 1'b0;
    if (in_exc_valid) begin
      dec_op_s   = {1'b1, in_exc_cause};
      dec_tval_s = in_exc_tval;
    end else if (opcode_s != OPC_SYSTEM) begin
      dec_op_s   = {1'b1, CAUSE_ILLEGAL};
      dec_tval_s = {32'd0, in_insn};
    end else begin
      case (funct3_s)
        3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
          case (funct3_s[1:0])
            2'b01:   dec_op_s = SYSOP_CSR_W;
            2'b10:   dec_op_s = SYSOP_CSR_S;
            default: dec_op_s = SYSOP_CSR_C;
          endcase
          dec_tval_s  = {52'd0, imm_s};
          dec_wdata_s = funct3_s[2] ? {59'd0, rs1_fld_s} : in_rs1_data;
          dec_wb_en_s = (rd_fld_s != 5'd0);
        end
        3'b000: begin
          if (funct7_s == 7'b0001001) begin
            // sfence.vma: no csr request, refetch after it
            dec_fence_s = 1'b1;
          end else begin
            case (imm_s)
              12'h000: begin
                case (priv)
                  2'b00:   dec_op_s = {1'b1, 4'd8};
                  2'b01:   dec_op_s = {1'b1, 4'd9};
                  default: dec_op_s = {1'b1, 4'd11};
                endcase
              end
              12'h001: begin
                dec_op_s   = {1'b1, CAUSE_BREAK};
                dec_tval_s = in_pc;
              end
              12'h302, 12'h102: dec_op_s = SYSOP_RET;
              12'h105:          dec_fence_s = 1'b1;
              default: begin
                dec_op_s   = {1'b1, CAUSE_ILLEGAL};
                dec_tval_s = {32'd0, in_insn};
              end
            endcase
          end
        end
        default: begin
          dec_op_s   = {1'b1, CAUSE_ILLEGAL};
          dec_tval_s = {32'd0, in_insn};
        end
      endcase
    end
  end

  // Next-state and next-output logic; every output is registered from these
  always_comb begin
    state_s       = state_r;
    in_ready_s    = 1'b0;
    op_s          = SYSOP_NOP;
    pc_s          = pc_r;
    tval_s        = tval_r;
    wdata_s       = wdata_r;
    wb_valid_s    = 1'b0;
    wb_rd_s       = 5'd0;
    wb_data_s     = 64'd0;
    redir_valid_s = 1'b0;
    redir_pc_s    = redir_pc_r;
    flush_s       = 1'b0;
    flush_cnt_s   = flush_cnt_r;
    rd_s          = rd_r;
    wb_en_s       = wb_en_r;
    fence_s       = fence_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_ISSUE;
          op_s    = dec_op_s;
          pc_s    = in_pc;
          tval_s  = dec_tval_s;
          wdata_s = dec_wdata_s;
          rd_s    = rd_fld_s;
          wb_en_s = dec_wb_en_s;
          fence_s = dec_fence_s;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      ST_ISSUE: begin
        // csr has acted on op at this edge; its answer decides the exit path
        if (trap_en || fence_r) begin
          state_s       = ST_FLUSH;
          redir_valid_s = 1'b1;
          redir_pc_s    = trap_en ? trap_pc : (pc_r + 64'd4);
          flush_s       = 1'b1;
          flush_cnt_s   = FLUSH_LOAD;
        end else begin
          state_s    = ST_DONE;
          wb_valid_s = wb_en_r;
          wb_rd_s    = wb_en_r ? rd_r : 5'd0;
          wb_data_s  = wb_en_r ? rdata : 64'd0;
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        in_ready_s = 1'b1;
      end
      ST_FLUSH: begin
        if (flush_cnt_r == 4'd0) begin
          state_s    = ST_IDLE;
          in_ready_s = 1'b1;
        end else begin
          flush_s     = 1'b1;
          flush_cnt_s = flush_cnt_r - 4'd1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        in_ready_s = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      in_ready_r    <= 1'b1;
      op_r          <= SYSOP_NOP;
      pc_r          <= 64'd0;
      tval_r        <= 64'd0;
      wdata_r       <= 64'd0;
      wb_valid_r    <= 1'b0;
      wb_rd_r       <= 5'd0;
      wb_data_r     <= 64'd0;
      redir_valid_r <= 1'b0;
      redir_pc_r    <= 64'd0;
      flush_r       <= 1'b0;
      flush_cnt_r   <= 4'd0;
      rd_r          <= 5'd0;
      wb_en_r       <= 1'b0;
      fence_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      in_ready_r    <= in_ready_s;
      op_r          <= op_s;
      pc_r          <= pc_s;
      tval_r        <= tval_s;
      wdata_r       <= wdata_s;
      wb_valid_r    <= wb_valid_s;
      wb_rd_r       <= wb_rd_s;
      wb_data_r     <= wb_data_s;
      redir_valid_r <= redir_valid_s;
      redir_pc_r    <= redir_pc_s;
      flush_r       <= flush_s;
      flush_cnt_r   <= flush_cnt_s;
      rd_r          <= rd_s;
      wb_en_r       <= wb_en_s;
      fence_r       <= fence_s;
    end
  end

  assign in_ready       = in_ready_r;
  assign op             = op_r;
  assign pc             = pc_r;
  assign tval           = tval_r;
  assign wdata          = wdata_r;
  assign wb_valid       = wb_valid_r;
  assign wb_rd          = wb_rd_r;
  assign wb_data        = wb_data_r;
  assign redirect_valid = redir_valid_r;
  assign redirect_pc    = redir_pc_r;
  assign flush          = flush_r;

`ifdef SYS_ISSUE_TRACE_EN
  logic [63:0] retire_cnt_r;

  // Count every issued request and log it together with each redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_r <= 64'd0;
    end else begin
      if (state_r == ST_ISSUE) begin
        retire_cnt_r <= retire_cnt_r + 64'd1;
        $display("%0t sysop #%0d pc=%h op=%h tval=%h wdata=%h",
                 $time, retire_cnt_r, pc_r, op_r, tval_r, wdata_r);
      end
      if (redir_valid_r) begin
        $display("%0t sysop redirect to %h", $time, redir_pc_r);
      end
    end
  end
`endif

endmodule
